mmio_uart_tx: RTL and testbench

Memory-mapped UART transmitter attached to the beaver32rv data-memory bus, downstream of the core's store path. It decodes core stores into a small transmit FIFO and serialises bytes 8N1 on `tx`, so programs running on the single-cycle core can emit characters. The core cannot stall, so a store to a full FIFO is dropped and recorded in a sticky overflow flag. The block sits beside `data_mem` and shares the same `MemWrite`/`MemRead`, address and write-data signals.

---
 rtl/beaver32rv_pkg.sv | 21 ++
 rtl/mmio_uart_tx_if.sv | 27 ++
 rtl/sync_fifo.sv | 45 ++++
 rtl/mmio_uart_tx.sv | 170 +++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/beaver32rv_pkg.sv
// Shared beaver32rv definitions: UART TX FSM states, MMIO register offsets
// and STATUS bit positions.
package beaver32rv_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } uart_tx_state_t;

    localparam logic [31:0] UART_TXDATA_OFS = 32'h0000_0000;
    localparam logic [31:0] UART_STATUS_OFS = 32'h0000_0004;

    localparam int unsigned UART_STAT_FULL_BIT  = 0;
    localparam int unsigned UART_STAT_EMPTY_BIT = 1;
    localparam int unsigned UART_STAT_BUSY_BIT  = 2;
    localparam int unsigned UART_STAT_OVF_BIT   = 3;

endpackage

// File: rtl/mmio_uart_tx_if.sv
// Core data-memory bus slice seen by MMIO peripherals: store/load strobes,
// address, store data and combinational load data.
interface mmio_uart_tx_if;

    logic        mem_write;
    logic        mem_read;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic [31:0] read_data;

    modport master (
        output mem_write,
        output mem_read,
        output addr,
        output write_data,
        input  read_data
    );

    modport slave (
        input  mem_write,
        input  mem_read,
        input  addr,
        input  write_data,
        output read_data
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB wrap pointers. A push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic             do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS decode, FIFO, baud timer
// and frame FSM. Define UART_TX_PARITY_EN to add an even-parity bit.
module mmio_uart_tx
    import beaver32rv_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 16,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_1000
) (
    input  logic             clk,
    input  logic             rst,
    mmio_uart_tx_if.slave    bus,
    output logic             tx,
    output logic             tx_busy
);

    localparam int unsigned    BW        = $clog2(CLK_DIV);
    localparam logic [BW-1:0]  BAUD_LAST = BW'(CLK_DIV - 1);

    uart_tx_state_t state_q, state_d;
    logic [BW-1:0]  baud_q, baud_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [7:0]     shift_q, shift_d;
    logic           tx_q, tx_d;
    logic           overflow_q, overflow_d;
`ifdef UART_TX_PARITY_EN
    logic           parity_q, parity_d;
`endif

    logic       sel_data, sel_status;
    logic       push_req, ovf_set, ovf_clr;
    logic       pop, load, baud_end;
    logic [7:0] fifo_rdata;
    logic       fifo_full, fifo_empty;
    logic       unused_wdata;

    assign sel_data     = (bus.addr == BASE_ADDR + UART_TXDATA_OFS);
    assign sel_status   = (bus.addr == BASE_ADDR + UART_STATUS_OFS);
    assign push_req     = bus.mem_write && sel_data;
    assign unused_wdata = ^bus.write_data[31:8];

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req),
        .wdata (bus.write_data[7:0]),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // A pop in the same cycle frees a slot, so the store is not an overflow.
    assign ovf_set = push_req && fifo_full && !pop;
    assign ovf_clr = bus.mem_write && sel_status && bus.write_data[UART_STAT_OVF_BIT];

    always_comb begin
        overflow_d = overflow_q;
        if (ovf_set)      overflow_d = 1'b1;
        else if (ovf_clr) overflow_d = 1'b0;
    end

    always_comb begin
        bus.read_data = '0;
        if (bus.mem_read && sel_status) begin
            bus.read_data[UART_STAT_FULL_BIT]  = fifo_full;
            bus.read_data[UART_STAT_EMPTY_BIT] = fifo_empty;
            bus.read_data[UART_STAT_BUSY_BIT]  = tx_busy;
            bus.read_data[UART_STAT_OVF_BIT]   = overflow_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        load      = 1'b0;
        baud_end  = (baud_q == BAUD_LAST);

        if (state_q != StIdle) baud_d = baud_end ? '0 : baud_q + BW'(1);

        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) load = 1'b1;
            end
            StStart: begin
                if (baud_end) state_d = StData;
            end
            StData: begin
                if (baud_end) begin
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
`ifdef UART_TX_PARITY_EN
                    if (bit_cnt_q == 3'd7) state_d = StParity;
`else
                    if (bit_cnt_q == 3'd7) state_d = StStop;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                if (baud_end) state_d = StStop;
            end
`endif
            StStop: begin
                if (baud_end) begin
                    if (!fifo_empty) load = 1'b1;
                    else             state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Back-to-back frames reload straight from STOP without an idle cycle.
        if (load) begin
            state_d   = StStart;
            shift_d   = fifo_rdata;
            bit_cnt_d = '0;
            baud_d    = '0;
`ifdef UART_TX_PARITY_EN
            parity_d  = ^fifo_rdata;
`endif
        end
        pop = load;

        unique case (state_d)
            StStart:  tx_d = 1'b0;
            StData:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            StParity: tx_d = parity_d;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            baud_q     <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    assign tx      = tx_q;
    assign tx_busy = (state_q != StIdle);

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx: stimulus queues expected frames and load
// data; independent monitors decode tx and compare load results.
module tb_mmio_uart_tx;

    localparam int unsigned CD  = 4;
    localparam logic [31:0] TXD = 32'h0000_1000;
    localparam logic [31:0] STA = 32'h0000_1004;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FL = NB * CD;

    typedef struct {
        logic [7:0] data;
        int         start;
        int         gap;
    } frame_t;

    logic clk;
    logic rst;
    logic tx;
    logic tx_busy;
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;

    frame_t      exp_q [$];
    logic [31:0] rd_q  [$];

    mmio_uart_tx_if bus ();

    mmio_uart_tx #(
        .CLK_DIV    (CD),
        .FIFO_DEPTH (4),
        .BASE_ADDR  (TXD)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .tx      (tx),
        .tx_busy (tx_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [10:0] exp_bits(input logic [7:0] d);
        logic [10:0] b;
        b      = '1;
        b[0]   = 1'b0;
        b[8:1] = d;
`ifdef UART_TX_PARITY_EN
        b[9]   = ^d;
`endif
        return b;
    endfunction

    // Frame monitor: decodes every frame on tx and scores it against exp_q.
    int          fm_start, fm_prev_end = -1000;
    bit          fm_abort, fm_stable, fm_busy;
    logic [10:0] fm_got;
    frame_t      fm_e;

    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && tx === 1'b0) begin
                fm_start  = cyc;
                fm_abort  = 1'b0;
                fm_stable = 1'b1;
                fm_busy   = 1'b1;
                fm_got    = '1;
                for (int i = 0; i < FL; i++) begin
                    if (i > 0) @(negedge clk);
                    if (rst !== 1'b1) begin
                        fm_abort = 1'b1;
                        break;
                    end
                    if (i % CD == 0) fm_got[i / CD] = tx;
                    else if (tx !== fm_got[i / CD]) fm_stable = 1'b0;
                    if (tx_busy !== 1'b1) fm_busy = 1'b0;
                end
                if (!fm_abort) begin
                    if (exp_q.size() == 0) begin
                        check("frame_expected", 32'(exp_q.size()), 32'd1);
                    end else begin
                        fm_e = exp_q.pop_front();
                        check("frame_bits", 32'(fm_got), 32'(exp_bits(fm_e.data)));
                        check("frame_shape", {30'd0, fm_stable, fm_busy}, 32'd3);
                        if (fm_e.start >= 0) check("frame_start", fm_start, fm_e.start);
                        if (fm_e.gap >= 0)   check("frame_gap", fm_start - fm_prev_end, fm_e.gap);
                    end
                    fm_prev_end = fm_start + FL;
                end
            end
        end
    end

    // Load monitor: every cycle with mem_read high consumes one expected value.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.mem_read === 1'b1) begin
                if (rd_q.size() == 0) check("read_expected", 32'(rd_q.size()), 32'd1);
                else check("read_data", bus.read_data, rd_q.pop_front());
            end
        end
    end

    task automatic store(input logic [31:0] a, input logic [31:0] d, output int c);
        @(posedge clk);
        #1;
        bus.mem_write  = 1'b1;
        bus.mem_read   = 1'b0;
        bus.addr       = a;
        bus.write_data = d;
        c = cyc;
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] exp);
        @(posedge clk);
        #1;
        bus.mem_write = 1'b0;
        bus.mem_read  = 1'b1;
        bus.addr      = a;
        rd_q.push_back(exp);
        @(negedge clk);
        #1;
        bus.mem_read = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        bus.mem_write = 1'b0;
        bus.mem_read  = 1'b0;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_frame(input logic [7:0] d, input int start, input int gap);
        frame_t f;
        f.data  = d;
        f.start = start;
        f.gap   = gap;
        exp_q.push_back(f);
    endtask

    int c0, cx;

    initial begin
        rst            = 1'b0;
        bus.mem_write  = 1'b0;
        bus.mem_read   = 1'b0;
        bus.addr       = '0;
        bus.write_data = '0;

        // Reset state and a reset dropped in the middle of a data bit.
        load(STA, 32'h2);
        @(posedge clk);
        #1;
        rst = 1'b1;
        store(TXD, 32'h55, c0);
        idle();
        wait_cyc(c0 + 8);
        #2;
        rst = 1'b0;
        #1;
        check("reset_tx", {31'd0, tx}, 32'd1);
        check("reset_busy", {31'd0, tx_busy}, 32'd0);
        load(STA, 32'h2);
        rst = 1'b1;

        // Single frame: 0xA5 with upper store bits ignored.
        store(TXD, 32'h1A5, c0);
        expect_frame(8'hA5, c0 + 2, -1);
        idle();
        wait_cyc(c0 + 2 + FL + 3);
        check("single_busy_done", {31'd0, tx_busy}, 32'd0);

        // Three back-to-back stores give contiguous frames.
        store(TXD, 32'h41, c0);
        store(TXD, 32'h42, cx);
        store(TXD, 32'h43, cx);
        expect_frame(8'h41, c0 + 2, -1);
        expect_frame(8'h42, -1, 0);
        expect_frame(8'h43, -1, 0);
        idle();
        wait_cyc(c0 + 2 + 2 * FL + 4);
        load(STA, 32'h6);
        wait_cyc(c0 + 2 + 3 * FL + 3);
        check("b2b_busy_done", {31'd0, tx_busy}, 32'd0);

        // Six stores: one pops, four fill the FIFO, the sixth overflows.
        store(TXD, 32'h11, c0);
        for (int i = 1; i < 6; i++) store(TXD, 32'h11 + i, cx);
        expect_frame(8'h11, c0 + 2, -1);
        for (int i = 1; i < 5; i++) expect_frame(8'(8'h11 + i), -1, 0);
        load(STA, 32'hD);
        store(STA, 32'h8, cx);
        load(STA, 32'h5);
        idle();
        wait_cyc(c0 + 2 + 5 * FL + 3);
        check("ovf_busy_done", {31'd0, tx_busy}, 32'd0);
        load(STA, 32'h2);

        // Store to a full FIFO on the edge that ends STOP and pops.
        store(TXD, 32'h21, c0);
        for (int i = 1; i < 5; i++) store(TXD, 32'h21 + i, cx);
        idle();
        wait_cyc(c0 + FL);
        store(TXD, 32'h26, cx);
        expect_frame(8'h21, c0 + 2, -1);
        for (int i = 1; i < 6; i++) expect_frame(8'(8'h21 + i), -1, 0);
        load(STA, 32'h5);
        wait_cyc(c0 + 2 + 6 * FL + 3);
        check("popfull_busy_done", {31'd0, tx_busy}, 32'd0);

        // Parity-sensitive byte, then decode of unmapped and ungated loads.
        store(TXD, 32'h07, c0);
        expect_frame(8'h07, c0 + 2, -1);
        idle();
        wait_cyc(c0 + 2 + FL + 3);
        check("par_busy_done", {31'd0, tx_busy}, 32'd0);
        load(32'h0000_2000, 32'h0);
        load(TXD, 32'h0);
        load(STA, 32'h2);
        @(posedge clk);
        #1;
        bus.addr = STA;
        @(negedge clk);
        check("status_no_read", bus.read_data, 32'h0);

        repeat (4) @(posedge clk);
        check("frames_pending", 32'(exp_q.size()), 32'd0);
        check("reads_pending", 32'(rd_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
